// File: rtl/calc_display_scan_if.sv
// Digit-stream input and seven-segment output bundle for calc_display_scan.
// master = calculator core / bench side, slave = display scanner.
interface calc_display_scan_if;
  logic [3:0] data;
  logic [3:0] pos;
  logic [1:0] status;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output data, pos, status,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  data, pos, status,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/calc_display_scan.sv
// Double-buffered 8-digit frame assembler and common-anode seven-segment scanner.
// Define ERR_BLINK_EN to make the sticky error screen blink (BLINK_DIV frames per half-period).
module calc_display_scan #(
  parameter int CLK_DIV = 50000
`ifdef ERR_BLINK_EN
  ,
  parameter int BLINK_DIV = 64
`endif
) (
  input  logic clock,
  input  logic reset,
  calc_display_scan_if.slave bus
);
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [3:0]    r_shadow [8];
  logic [3:0]    r_active [8];
  logic [PW-1:0] r_presc;
  logic [2:0]    r_scan_idx;
  logic          r_err;
  logic          r_end_prev;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_end;
  logic          w_commit;
  logic          w_dark;
  logic [7:0]    w_lz;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;

  assign w_tick   = (r_presc == PW'(CLK_DIV - 1));
  assign w_end    = bus.pos[3];
  assign w_commit = w_end && !r_end_prev;

  // w_lz[i]: digit i and everything above it are zero, so digit i is a leading zero
  assign w_lz[7] = (r_active[7] == 4'd0);
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_lz
      if (gi == 0) begin : g_units
        assign w_lz[gi] = 1'b0;
      end else begin : g_upper
        assign w_lz[gi] = (r_active[gi] == 4'd0) && w_lz[gi+1];
      end
    end
  endgenerate

`ifdef ERR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV) + 1;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_tick && r_scan_idx == 3'd7) begin
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_dark = r_err && !r_blink_phase;
`else
  assign w_dark = 1'b0;
`endif

  always_comb begin
    w_digit = r_active[r_scan_idx];
    case (w_digit)
      4'h0:    w_seg = 7'h40;
      4'h1:    w_seg = 7'h79;
      4'h2:    w_seg = 7'h24;
      4'h3:    w_seg = 7'h30;
      4'h4:    w_seg = 7'h19;
      4'h5:    w_seg = 7'h12;
      4'h6:    w_seg = 7'h02;
      4'h7:    w_seg = 7'h78;
      4'h8:    w_seg = 7'h00;
      4'h9:    w_seg = 7'h10;
      4'hF:    w_seg = 7'h3F;
      default: w_seg = 7'h7F;
    endcase
    if (r_err) begin
      case (r_scan_idx)
        3'd3:        w_seg = 7'h06;
        3'd2, 3'd1:  w_seg = 7'h2F;
        3'd0:        w_seg = 7'h23;
        default:     w_seg = 7'h7F;
      endcase
    end else if (w_lz[r_scan_idx]) begin
      w_seg = 7'h7F;
    end
    if (w_dark) begin
      w_seg = 7'h7F;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 4'd0;
        r_active[i] <= 4'd0;
      end
      r_presc      <= '0;
      r_scan_idx   <= 3'd0;
      r_err        <= 1'b0;
      r_end_prev   <= 1'b0;
      r_an         <= 8'hFF;
      r_seg        <= 7'h7F;
      r_frame_done <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_scan_idx <= r_scan_idx + 3'd1;
      end
      if (bus.status == 2'b01 && !w_end) begin
        r_shadow[bus.pos[2:0]] <= bus.data;
      end
      // Capture needs pos <= 7 and commit needs pos > 7, so they never collide
      if (w_commit) begin
        for (int i = 0; i < 8; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (bus.status == 2'b00) begin
        r_err <= 1'b1;
      end
      r_end_prev   <= w_end;
      r_frame_done <= w_commit;
      r_an         <= ~(8'd1 << r_scan_idx);
      r_seg        <= w_seg;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = 1'b1;
  assign bus.frame_done = r_frame_done;
endmodule
